// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: default sample width, decimation and buffering sizes.
// Pure declarations; no timing or flow control of its own.
package fir_pkg;

   localparam int FIR_DATA_WIDTH = 8;
   localparam int FIR_DECIM      = 4;
   localparam int FIR_FIFO_DEPTH = 4;

   typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;

   // Ceiling log2 for flows whose $clog2 support is unreliable in constant contexts.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_decimator_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid in the same cycle as !empty, 0 when empty.
// A push into a full FIFO is taken only alongside a pop; pops on empty are ignored.
module sample_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = FIR_DATA_WIDTH,
   parameter int DEPTH = FIR_FIFO_DEPTH
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(DEPTH):0]     level,
   output logic [WIDTH-1:0]          head
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit separates a full lap from an empty buffer.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump average of every DECIM valid samples, buffered for a valid/ready consumer.
// Result visible the cycle after the last sample of a block; results hitting a full, unpopped FIFO are dropped and flagged.
module fir_decimator
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int DECIM      = FIR_DECIM,
   parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       x_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       y_out,
   output logic [clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                        overflow
);

   localparam int LOG_D = clog2(DECIM);
   localparam int ACC_W = DATA_WIDTH + LOG_D;
   localparam logic [LOG_D-1:0] LAST_PHASE = LOG_D'(DECIM - 1);
   localparam logic [LOG_D-1:0] PHASE_ONE  = 1;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic [LOG_D-1:0]        phase;
   logic [DATA_WIDTH-1:0]   result;
   logic                    last;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign x_ext   = {{LOG_D{x_in[DATA_WIDTH-1]}}, x_in};
   assign acc_sum = acc + x_ext;
   assign last    = in_valid && (phase == LAST_PHASE);
   // Dropping the low LOG_D bits is the floor division; the upper bits fit DATA_WIDTH exactly.
   assign result  = acc_sum[ACC_W-1:LOG_D];
   assign pop     = out_valid && out_ready;
   assign out_valid = !fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         phase    <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_valid) begin
            acc   <= (phase == '0) ? x_ext : acc_sum;
            phase <= phase + PHASE_ONE;
         end
         if (last && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   sample_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (last),
      .push_data (result),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .head      (y_out)
   );

endmodule

// File: tb/tb_fir_decimator.sv
// Directed plus randomized check of fir_decimator against a queue-based averaging model.
module tb_fir_decimator;
   import fir_pkg::*;

   localparam int DW    = 8;
   localparam int DEC   = 4;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] x_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] y_out;
   logic [2:0]    fifo_level;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   int cur_blk[$];
   int mq[$];
   bit m_ovf = 0;

   fir_decimator #(
      .DATA_WIDTH (DW),
      .DECIM      (DEC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .x_in       (x_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y_out      (y_out),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int floor_avg(input int s);
      if (s >= 0) return s / DEC;
      return -((-s + DEC - 1) / DEC);
   endfunction

   // Reference: collect DECIM samples, average with floor, FIFO as a bounded queue.
   always @(posedge clk or negedge reset) begin : model
      bit m_pop;
      int s;
      if (!reset) begin
         cur_blk.delete();
         mq.delete();
         m_ovf = 0;
      end else begin
         m_pop = (mq.size() > 0) && out_ready;
         if (m_pop) void'(mq.pop_front());
         if (in_valid) begin
            cur_blk.push_back(int'($signed(x_in)));
            if (cur_blk.size() == DEC) begin
               s = 0;
               foreach (cur_blk[i]) s += cur_blk[i];
               cur_blk.delete();
               if (mq.size() < DEPTH) mq.push_back(floor_avg(s));
               else m_ovf = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
         chk("y_out", int'($signed(y_out)), (mq.size() > 0) ? mq[0] : 0);
         chk("fifo_level", int'(fifo_level), mq.size());
         chk("overflow", int'(overflow), int'(m_ovf));
      end
   end

   task automatic cyc(input bit v, input int x, input bit rdy);
      in_valid  = v;
      x_in      = DW'(x);
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic blk4(input int a, input int b, input int c, input int d, input bit rdy);
      cyc(1, a, rdy);
      cyc(1, b, rdy);
      cyc(1, c, rdy);
      cyc(1, d, rdy);
   endtask

   task automatic pulse_reset;
      reset = 0;
      #2;
      reset = 1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_valid"}, int'(out_valid), 0);
      chk({name, "_y"}, int'($signed(y_out)), 0);
      chk({name, "_level"}, int'(fifo_level), 0);
      chk({name, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      bit v;
      bit rdy;
      int x;
      int pick;
      reset     = 1;
      in_valid  = 0;
      x_in      = '0;
      out_ready = 0;
      #1;
      reset  = 0;
      chk_en = 1;
      @(posedge clk);
      #1;
      chk_idle("reset");
      @(posedge clk);
      #1;
      reset = 1;

      // Plain averages.
      blk4(1, 2, 3, 4, 1);
      chk("avg1234_valid", int'(out_valid), 1);
      chk("avg1234_y", int'($signed(y_out)), 2);
      chk("avg1234_model", mq[0], 2);
      cyc(1, 8, 1);
      chk("avg_one_cycle", int'(out_valid), 0);
      cyc(1, 8, 1);
      cyc(1, 8, 1);
      cyc(1, 8, 1);
      chk("avg8_y", int'($signed(y_out)), 8);

      // Floor rounding and extremes.
      blk4(-1, -1, -1, -2, 1);
      chk("floor_y", int'($signed(y_out)), -2);
      chk("floor_model", mq[0], -2);
      blk4(127, 127, 127, 127, 1);
      chk("max_y", int'($signed(y_out)), 127);
      blk4(-128, -128, -128, -128, 1);
      chk("min_y", int'($signed(y_out)), -128);
      cyc(0, 0, 1);

      // Gapped input with junk on idle cycles.
      for (int k = 0; k < 4; k++) begin
         cyc(1, 4, 1);
         if (k == 3) chk("gap_y", int'($signed(y_out)), 4);
         cyc(0, 99, 1);
      end
      cyc(0, 99, 1);
      cyc(0, 99, 1);
      chk("gap_single_level", int'(fifo_level), 0);

      // Back-pressure and overflow.
      for (int k = 1; k <= 5; k++) blk4(k, k, k, k, 0);
      chk("bp_level", int'(fifo_level), 4);
      chk("bp_ovf", int'(overflow), 1);
      for (int k = 1; k <= 4; k++) begin
         chk("bp_drain_valid", int'(out_valid), 1);
         chk("bp_drain_y", int'($signed(y_out)), k);
         cyc(0, 0, 1);
      end
      chk("bp_empty_valid", int'(out_valid), 0);
      chk("bp_empty_y", int'($signed(y_out)), 0);

      // Full FIFO with push and pop on the same edge.
      pulse_reset();
      blk4(10, 10, 10, 10, 0);
      blk4(20, 20, 20, 20, 0);
      blk4(30, 30, 30, 30, 0);
      blk4(40, 40, 40, 40, 0);
      chk("full_level", int'(fifo_level), 4);
      cyc(1, 50, 0);
      cyc(1, 50, 0);
      cyc(1, 50, 0);
      cyc(1, 50, 1);
      chk("simul_level", int'(fifo_level), 4);
      chk("simul_ovf", int'(overflow), 0);
      chk("simul_y", int'($signed(y_out)), 20);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("simul_tail_y", int'($signed(y_out)), 50);
      cyc(0, 0, 1);

      // Asynchronous reset in the middle of a block.
      cyc(1, 100, 1);
      cyc(1, 100, 1);
      in_valid = 0;
      reset = 0;
      #1;
      chk_idle("midrst");
      #1;
      reset = 1;
      blk4(4, 4, 4, 4, 1);
      chk("midrst_y", int'($signed(y_out)), 4);
      cyc(0, 0, 1);

      // Randomized traffic with alternating back-pressure regimes.
      for (int i = 0; i < 3000; i++) begin
         pick = $urandom_range(0, 99);
         v    = ($urandom_range(0, 99) < 70);
         if (((i / 200) % 2) == 1) rdy = ($urandom_range(0, 99) < 85);
         else rdy = ($urandom_range(0, 99) < 25);
         x = $urandom_range(0, 255);
         if (pick < 10) x = 127;
         else if (pick < 20) x = 128;
         if (i == 1500) pulse_reset();
         cyc(v, x, rdy);
      end

      @(negedge clk);
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Decimating output stage placed directly downstream of the FIR filter. It consumes one filtered sample per valid cycle and averages each block of DECIM samples with an integrate-and-dump accumulator. The resulting rate-reduced samples are buffered in a small FIFO and presented to the next consumer through a valid/ready handshake.

## Interface
- DATA_WIDTH, 8: signed sample width, same on input and output.
- DECIM, 4: decimation factor; power of two, ≥2.
- FIFO_DEPTH, 4: output buffer entries; power of two, ≥2.

- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
- in_valid  input  1  x_in carries a sample this cycle; no back-pressure upstream.
- x_in  input  DATA_WIDTH  signed filtered sample.
- out_valid  output  1  y_out holds a buffered result (FIFO non-empty).
- out_ready  input  1  consumer accepts y_out this cycle.
- y_out  output  DATA_WIDTH  signed decimated sample (FIFO head).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently buffered.
- overflow  output  1  sticky; a result was dropped because the FIFO was full.

## Operation
- ACC_W = DATA_WIDTH + log2(DECIM); accumulator is signed ACC_W, so it can never wrap.
- Phase counter 0..DECIM-1 advances only on in_valid. Cycles without in_valid leave the phase and accumulator unchanged.
- in_valid at phase 0: acc <= sext(x_in). At other phases: acc <= acc + sext(x_in).
- in_valid at phase DECIM-1: result = (acc + x_in) >>> log2(DECIM), an arithmetic floor shift truncated to DATA_WIDTH. The result is pushed to the FIFO and the phase returns to 0.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the result is dropped and overflow <= 1.
- overflow clears only on reset.
- Pop occurs when out_valid && out_ready. A pop with the FIFO empty is impossible by construction.
- Read and write pointers wrap modulo FIFO_DEPTH. One extra bit distinguishes full from empty.
- y_out = 0 whenever the FIFO is empty; it never shows stale or X data.
- Results leave in arrival order; no reordering or duplication.

## Timing
- Reset values: acc 0, phase 0, pointers 0, fifo_level 0, out_valid 0, y_out 0, overflow 0.
- Reset asserted mid-block discards the partial sum and all buffered entries immediately. It is asynchronous and needs no clock.
- Latency: the result of a block whose last sample is accepted on edge t appears on y_out with out_valid=1 immediately after edge t, when the FIFO was empty before the push.
- out_valid and y_out are held stable until popped; y_out changes only on a pop or on a push into an empty FIFO.
- Push and pop in the same cycle, non-empty: fifo_level unchanged.
- Push and pop in the same cycle, full: push accepted, level stays FIFO_DEPTH, overflow not set.
- Full throughput: one result per DECIM valid inputs and one pop per cycle; no bubbles are inserted.

## Structure
- Shared package fir_pkg: DATA_WIDTH default and the sample typedef, shared with the FIR filter.
- DECIM and FIFO_DEPTH defaults also live in fir_pkg, plus a clog2 helper if the tool flow lacks $clog2.
- One sub-module, sample_fifo: a synchronous FWFT FIFO with push, pop, full, empty, level and head outputs, parameterised by width and depth.
- The accumulator, phase counter and overflow flag stay in fir_decimator.

## Test plan
Defaults DATA_WIDTH=8, DECIM=4, FIFO_DEPTH=4 throughout.
- Average: x_in 1,2,3,4 on consecutive valid cycles, out_ready=1 -> out_valid for one cycle after the 4th sample with y_out=2. Next block 8,8,8,8 -> y_out=8.
- Floor rounding: -1,-1,-1,-2 -> y_out=-2. Extremes: 127×4 -> y_out=127; -128×4 -> y_out=-128, with no wrap.
- Gapped input: valid samples 4,4,4,4 interleaved with idle cycles, x_in=99 on idle cycles -> exactly one output, y_out=4.
- Back-pressure: out_ready=0, five blocks with averages 1..5 -> fifo_level=4 and overflow=1. Then out_ready=1 -> y_out 1,2,3,4 on four consecutive cycles, then out_valid=0 and y_out=0.
- Full with simultaneous events: FIFO full, block completes in a cycle where out_ready=1 -> push accepted, level stays 4, overflow stays 0.
- Reset mid-block: accept 100,100, pulse reset low between edges -> all outputs at reset values. Then accept 4,4,4,4 -> y_out=4, with no contribution from the earlier 100s.
